audio_i2s_tx: RTL and testbench
===============================

Name: audio_i2s_tx

Overview:
Serializes the stereo 16-bit output of the audio filter chain (the IIR/DC-blocker outputs, updated on sample_ce) into a standard I2S stream for the external DAC/HDMI audio path. Samples are captured into a small FIFO on sample_ce and read out once per I2S frame. The block generates bclk and lrclk locally from clk by an integer divider. It reports underrun and overrun as single-cycle pulses.

Parameters:
CLK_DIV, 8, clk cycles per bclk half-period; minimum 2; bclk period = 2*CLK_DIV clk.
FIFO_DEPTH, 4, sample FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
sample_ce  in  1  push strobe; one {in_l,in_r} pair per pulse
in_l  in  16  signed left sample
in_r  in  16  signed right sample
enable  in  1  1 = run serializer; 0 = stop at end of current frame
mute  in  1  1 = transmit zeros; FIFO still drains
i2s_bclk  out  1  bit clock
i2s_lrclk  out  1  word select; 0 = left, 1 = right
i2s_data  out  1  serial data, MSB first
underrun  out  1  1-clk pulse: frame start with FIFO empty
overrun  out  1  1-clk pulse: push dropped because FIFO was full
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: every output is 0. FIFO is empty. Divider, slot counter and shift register are 0. FSM is in IDLE. Reset may be asserted at any time, including mid-frame, with an immediate effect.
- FSM states:
  - IDLE: bclk, lrclk and data are held at 0; the divider is held at 0. enable=1 -> START.
  - START: one clk. Loads the frame, sets slot=0, then -> RUN.
  - RUN: serializes frames. When enable=0 is sampled at the falling edge that ends slot 31, the FSM goes -> IDLE. A frame is never truncated except by reset.
- Divider:
  - div counts 0..CLK_DIV-1 in RUN.
  - On wrap, bclk toggles.
  - A toggle 1->0 is a "fall": slot advances modulo 32, and data and lrclk update on that same clk.
  - DAC samples on rising bclk.
- Frame: 32 slots, with a 32-bit shift register {L,R}.
  - Slot n drives bit (31-n) of the frame word.
  - lrclk = 1 for slots 15..30 and 0 for slots 31 and 0..14. Word select therefore leads the MSB by one bit (I2S).
- Frame load happens at START and at each fall into slot 0:
  - FIFO non-empty: pop the entry and load {L,R}, or load zeros if mute=1.
  - FIFO empty: load zeros and pulse underrun.
- Push: on sample_ce, {in_l,in_r} is written if the FIFO is not full. If it is full, the sample is dropped and overrun pulses. sample_ce is accepted in every state, including IDLE.
- Simultaneous push and pop:
  - FIFO full: the pop frees an entry and the push is accepted; no overrun.
  - FIFO empty: there is no bypass. The pop sees empty and underrun pulses; the push is accepted, so level = 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is 0..FIFO_DEPTH and is registered, updating the clk after push/pop.
- Latency: a sample pushed into an empty FIFO is popped at the next frame load. Its MSB appears on i2s_data at slot 0, i.e. in the same clk as that fall.

Decomposition:
- Package audio_i2s_pkg holds:
  - constants FRAME_SLOTS=32, SLOT_W=5, SAMPLE_W=16, LR_START_SLOT=15, LR_END_SLOT=30;
  - FSM state typedef {IDLE, START, RUN}.
- Sub-module audio_sample_fifo: 32-bit wide, FIFO_DEPTH deep, synchronous write/read, async reset; outputs empty, full, level.

Test Plan:
- Reset values: assert reset mid-RUN -> all outputs 0 within the same clk; level=0; after release with enable=0, outputs stay 0.
- Basic frame:
  - Stimulus: CLK_DIV=2, push L=0x8001 R=0x7FFE, enable=1.
  - Required response: slots 0..15 carry 1000000000000001 and slots 16..31 carry 0111111111111110 on falling bclk. lrclk rises entering slot 15 and falls entering slot 31. bclk period is 4 clk.
- Underrun: enable=1 with an empty FIFO -> underrun pulses once per frame, data is all 0, and fifo_level stays 0.
- Overrun: with enable=0, push 5 pairs (0x0001..0x0005) -> level=4 and a single overrun pulse on the 5th push. Then enable -> frames carry 1,2,3,4, then underrun.
- Mute: push 0x1234/0x5678 with mute=1 -> zeros transmitted, level decrements, no underrun.
- Simultaneous full push/pop: force sample_ce on the clk of the slot-0 fall with level=4 -> no overrun; level stays 4.
- Enable drop: deassert enable at slot 10 -> frame completes through slot 31, then IDLE with bclk=0 and lrclk=0.

Source files
------------

// File: rtl/audio_i2s_pkg.sv
// Shared constants, FSM state type and slot helper for the I2S transmitter.
package audio_i2s_pkg;

  localparam int FRAME_SLOTS   = 32;
  localparam int SLOT_W        = 5;
  localparam int SAMPLE_W      = 16;
  localparam int LR_START_SLOT = 15;
  localparam int LR_END_SLOT   = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } i2s_state_e;

  // Word select for a slot. It goes high one slot before the right-channel
  // MSB and drops one slot before the left-channel MSB of the next frame.
  function automatic logic lr_for_slot(input logic [SLOT_W-1:0] slot);
    return (slot >= SLOT_W'(LR_START_SLOT)) && (slot <= SLOT_W'(LR_END_SLOT));
  endfunction

endpackage

// File: rtl/audio_i2s_tx_fifo.sv
// audio_sample_fifo: small synchronous FIFO for {left,right} sample pairs.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   push, wdata   write strobe and data; ignored while full unless a pop
//                 happens in the same clk
//   pop, rdata    read strobe (ignored while empty), head-of-queue data
//   empty, full   occupancy flags derived from the registered level
//   level         registered occupancy 0..DEPTH
module audio_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (PTR_W+1)'(DEPTH));
  // No bypass: a pop on an empty FIFO does nothing even if a push arrives
  // in the same clk. A pop on a full FIFO frees room for a same-clk push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: buffers stereo 16-bit samples and serializes them as I2S.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   sample_ce           push strobe for {in_l,in_r}
//   in_l, in_r          signed left/right samples
//   enable              run serializer; dropping it stops at end of frame
//   mute                transmit zeros while still draining the FIFO
//   i2s_bclk/lrclk/data I2S bit clock, word select (0 = left), data MSB first
//   underrun            1-clk pulse when a frame load finds the FIFO empty
//   overrun             1-clk pulse when a push is dropped on a full FIFO
//   fifo_level          registered FIFO occupancy
//
// state | meaning
// IDLE  | serializer stopped, bclk/lrclk/data/divider held at 0
// START | one clk: load first frame, slot 0
// RUN   | divider running; bclk falls advance slots, slot 31 end reloads
module audio_i2s_tx
  import audio_i2s_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_ce,
  input  logic [SAMPLE_W-1:0]           in_l,
  input  logic [SAMPLE_W-1:0]           in_r,
  input  logic                          enable,
  input  logic                          mute,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_data,
  output logic                          underrun,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  i2s_state_e              state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [2*SAMPLE_W-1:0]   shift_q, shift_d;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    data_q, data_d;
  logic                    underrun_q, underrun_d;
  logic                    overrun_q, overrun_d;

  logic                    fifo_pop;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [2*SAMPLE_W-1:0]   fifo_rdata;
  logic [2*SAMPLE_W-1:0]   load_word;
  logic [SLOT_W-1:0]       next_slot;
  logic                    frame_load;

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (sample_ce),
    .wdata ({in_l, in_r}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    slot_d     = slot_q;
    shift_d    = shift_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    data_d     = data_q;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    frame_load = 1'b0;
    load_word  = (fifo_empty || mute) ? '0 : fifo_rdata;
    next_slot  = slot_q + 1'b1;

    case (state_q)
      IDLE: begin
        div_d   = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        data_d  = 1'b0;
        slot_d  = '0;
        if (enable) begin
          state_d = START;
        end
      end
      START: begin
        div_d      = '0;
        bclk_d     = 1'b0;
        frame_load = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (div_q == DIV_MAX) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          // A falling bclk ends the current slot.
          if (bclk_q) begin
            if (slot_q == SLOT_W'(FRAME_SLOTS - 1)) begin
              if (!enable) begin
                state_d = IDLE;
                lrclk_d = 1'b0;
                data_d  = 1'b0;
                slot_d  = '0;
              end else begin
                frame_load = 1'b1;
              end
            end else begin
              slot_d  = next_slot;
              shift_d = {shift_q[2*SAMPLE_W-2:0], 1'b0};
              data_d  = shift_q[2*SAMPLE_W-2];
              lrclk_d = lr_for_slot(next_slot);
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The MSB is driven in the same clk as the load so slot 0 carries it.
    if (frame_load) begin
      fifo_pop   = 1'b1;
      underrun_d = fifo_empty;
      shift_d    = load_word;
      data_d     = load_word[2*SAMPLE_W-1];
      slot_d     = '0;
      lrclk_d    = lr_for_slot('0);
    end

    // A full FIFO is never empty, so a frame load always frees a slot here.
    overrun_d = sample_ce && fifo_full && !fifo_pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      slot_q     <= '0;
      shift_q    <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      data_q     <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      slot_q     <= slot_d;
      shift_q    <= shift_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_data  = data_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx. A bus monitor decodes the I2S lines
// as a DAC would (bits taken on rising bclk); scenario tasks compare decoded
// frames and pulse counts against a queue-based sample model.
module tb_audio_i2s_tx;

  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_CLKS = 32 * 2 * CLK_DIV;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sample_ce = 1'b0;
  logic [15:0]      in_l = '0;
  logic [15:0]      in_r = '0;
  logic             enable = 1'b0;
  logic             mute = 1'b0;
  logic             i2s_bclk, i2s_lrclk, i2s_data, underrun, overrun;
  logic [LVL_W-1:0] fifo_level;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  audio_i2s_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_ce  (sample_ce),
    .in_l       (in_l),
    .in_r       (in_r),
    .enable     (enable),
    .mute       (mute),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_data   (i2s_data),
    .underrun   (underrun),
    .overrun    (overrun),
    .fifo_level (fifo_level)
  );

  // ---------------- bus monitor ----------------
  bit     rx_data[$];
  bit     rx_lr[$];
  int     und_cnt = 0, ovr_cnt = 0, edge_bad = 0, period_bad = 0, level_max = 0;
  longint cyc = 0, last_rise = 0;
  bit     have_rise = 0;
  logic   prev_bclk = 0, prev_data = 0, prev_lr = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      prev_bclk = 0; prev_data = 0; prev_lr = 0; have_rise = 0;
    end else begin
      if (underrun) und_cnt++;
      if (overrun) ovr_cnt++;
      if (int'(fifo_level) > level_max) level_max = int'(fifo_level);
      if (i2s_bclk && !prev_bclk) begin
        rx_data.push_back(i2s_data);
        rx_lr.push_back(i2s_lrclk);
        if (have_rise && (cyc - last_rise) != 2 * CLK_DIV) period_bad++;
        have_rise = 1;
        last_rise = cyc;
      end else if (!i2s_bclk && (cyc - last_rise) > 2 * CLK_DIV) begin
        have_rise = 0;
      end
      // Data and word select must only move on the falling bclk.
      if (i2s_bclk && (i2s_data !== prev_data || i2s_lrclk !== prev_lr)) edge_bad++;
      prev_bclk = i2s_bclk; prev_data = i2s_data; prev_lr = i2s_lrclk;
    end
  end

  function automatic logic [31:0] frame_word(input int f);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) w[31-i] = rx_data[f*32+i];
    return w;
  endfunction

  function automatic bit lr_pattern_ok(input int f);
    for (int i = 0; i < 32; i++)
      if (rx_lr[f*32+i] != ((i >= 15) && (i <= 30))) return 0;
    return 1;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_data.delete(); rx_lr.delete();
    und_cnt = 0; ovr_cnt = 0; edge_bad = 0; period_bad = 0; level_max = 0;
  endtask

  task automatic do_reset();
    reset = 1; sample_ce = 0; enable = 0; mute = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    clear_mon();
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    in_l = l; in_r = r; sample_ce = 1;
    tick();
    sample_ce = 0;
  endtask

  task automatic wait_bits(input int n);
    int budget;
    budget = (n / 32 + 2) * FRAME_CLKS + 20;
    while (rx_data.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (rx_data.size() < n)
      $display("FAIL timeout waiting bits: got %0d want %0d", rx_data.size(), n);
    else
      n_pass++;
  endtask

  task automatic stop_at_frame_end();
    enable = 0;
    repeat (4 * CLK_DIV) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] w;
    int act;
    repeat (2) tick();
    n_checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_data, underrun, overrun} !== 5'b0 || fifo_level !== '0)
      $display("FAIL reset_init: outs=%b level=%0d want 0", {i2s_bclk, i2s_lrclk, i2s_data, underrun, overrun}, fifo_level);
    else n_pass++;

    do_reset();
    w = $urandom;
    push_pair(w[31:16], w[15:0]);
    push_pair(16'h1111, 16'h2222);
    enable = 1;
    wait_bits(20);
    n_checks++;
    if (i2s_lrclk !== 1'b1) $display("FAIL reset_pre_lrclk: got %b want 1", i2s_lrclk);
    else n_pass++;
    #2 reset = 1;
    #1;
    n_checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_data, underrun, overrun} !== 5'b0)
      $display("FAIL reset_async_outs: got %b want 00000", {i2s_bclk, i2s_lrclk, i2s_data, underrun, overrun});
    else n_pass++;
    n_checks++;
    if (fifo_level !== '0) $display("FAIL reset_async_level: got %0d want 0", fifo_level);
    else n_pass++;
    enable = 0;
    tick();
    reset = 0;
    act = 0;
    repeat (40) begin
      tick();
      if ({i2s_bclk, i2s_lrclk, i2s_data, underrun, overrun} !== 5'b0 || fifo_level !== '0) act++;
    end
    n_checks++;
    if (act != 0) $display("FAIL reset_idle_quiet: active cycles %0d want 0", act);
    else n_pass++;
  endtask

  task automatic test_basic_frame();
    do_reset();
    push_pair(16'h8001, 16'h7FFE);
    enable = 1;
    wait_bits(32);
    stop_at_frame_end();
    n_checks++;
    if (frame_word(0) !== 32'h8001_7FFE) $display("FAIL basic_word: got %h want 80017ffe", frame_word(0));
    else n_pass++;
    n_checks++;
    if (!lr_pattern_ok(0)) $display("FAIL basic_lrclk: slot pattern wrong, got 0 want 1");
    else n_pass++;
    n_checks++;
    if (period_bad != 0 || edge_bad != 0)
      $display("FAIL basic_timing: period_bad=%0d edge_bad=%0d want 0/0", period_bad, edge_bad);
    else n_pass++;
    n_checks++;
    if (und_cnt != 0 || fifo_level !== '0)
      $display("FAIL basic_drain: und=%0d level=%0d want 0/0", und_cnt, fifo_level);
    else n_pass++;
  endtask

  task automatic test_underrun();
    do_reset();
    enable = 1;
    wait_bits(96);
    stop_at_frame_end();
    n_checks++;
    if (und_cnt != 3) $display("FAIL underrun_count: got %0d want 3", und_cnt);
    else n_pass++;
    n_checks++;
    if (frame_word(0) !== 0 || frame_word(1) !== 0 || frame_word(2) !== 0)
      $display("FAIL underrun_data: got %h %h %h want 0", frame_word(0), frame_word(1), frame_word(2));
    else n_pass++;
    n_checks++;
    if (level_max != 0) $display("FAIL underrun_level: max %0d want 0", level_max);
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    for (int k = 1; k <= 5; k++) push_pair(16'(k), 16'(k));
    n_checks++;
    if (fifo_level !== LVL_W'(4) || ovr_cnt != 1)
      $display("FAIL overrun_fill: level=%0d ovr=%0d want 4/1", fifo_level, ovr_cnt);
    else n_pass++;
    enable = 1;
    wait_bits(160);
    stop_at_frame_end();
    for (int f = 0; f < 5; f++) begin
      logic [31:0] exp;
      exp = (f < 4) ? {16'(f + 1), 16'(f + 1)} : 32'h0;
      n_checks++;
      if (frame_word(f) !== exp) $display("FAIL overrun_frame%0d: got %h want %h", f, frame_word(f), exp);
      else n_pass++;
    end
    n_checks++;
    if (und_cnt != 1 || ovr_cnt != 1) $display("FAIL overrun_pulses: und=%0d ovr=%0d want 1/1", und_cnt, ovr_cnt);
    else n_pass++;
  endtask

  task automatic test_mute();
    do_reset();
    mute = 1;
    push_pair(16'h1234, 16'h5678);
    n_checks++;
    if (fifo_level !== LVL_W'(1)) $display("FAIL mute_level_pre: got %0d want 1", fifo_level);
    else n_pass++;
    enable = 1;
    wait_bits(32);
    stop_at_frame_end();
    n_checks++;
    if (frame_word(0) !== 32'h0) $display("FAIL mute_data: got %h want 0", frame_word(0));
    else n_pass++;
    n_checks++;
    if (fifo_level !== '0 || und_cnt != 0) $display("FAIL mute_drain: level=%0d und=%0d want 0/0", fifo_level, und_cnt);
    else n_pass++;
    mute = 0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] w[5];
    do_reset();
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++) push_pair(w[i][31:16], w[i][15:0]);
    enable = 1;
    wait_bits(2);
    push_pair(w[4][31:16], w[4][15:0]);
    wait_bits(32);
    repeat (CLK_DIV - 1) tick();
    n_checks++;
    if (fifo_level !== LVL_W'(4)) $display("FAIL pushpop_level_pre: got %0d want 4", fifo_level);
    else n_pass++;
    in_l = 16'hA5A5; in_r = 16'h5A5A; sample_ce = 1;
    tick();
    sample_ce = 0;
    n_checks++;
    if (i2s_bclk !== 1'b0 || i2s_lrclk !== 1'b0) $display("FAIL pushpop_at_fall: bclk=%b lr=%b want 0/0", i2s_bclk, i2s_lrclk);
    else n_pass++;
    n_checks++;
    if (ovr_cnt != 0 || fifo_level !== LVL_W'(4))
      $display("FAIL pushpop_no_overrun: ovr=%0d level=%0d want 0/4", ovr_cnt, fifo_level);
    else n_pass++;
    enable = 0;
    wait_bits(64);
    stop_at_frame_end();
    n_checks++;
    if (frame_word(0) !== w[0] || frame_word(1) !== w[1])
      $display("FAIL pushpop_frames: got %h %h want %h %h", frame_word(0), frame_word(1), w[0], w[1]);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    logic [31:0] w;
    int act;
    do_reset();
    w = $urandom;
    push_pair(w[31:16], w[15:0]);
    enable = 1;
    wait_bits(11);
    enable = 0;
    wait_bits(32);
    repeat (4 * CLK_DIV) tick();
    act = 0;
    repeat (60) begin
      tick();
      if ({i2s_bclk, i2s_lrclk, i2s_data} !== 3'b0) act++;
    end
    n_checks++;
    if (rx_data.size() != 32) $display("FAIL drop_bits: got %0d want 32", rx_data.size());
    else n_pass++;
    n_checks++;
    if (frame_word(0) !== w) $display("FAIL drop_word: got %h want %h", frame_word(0), w);
    else n_pass++;
    n_checks++;
    if (act != 0) $display("FAIL drop_idle: active cycles %0d want 0", act);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [31:0] model[$];
      logic [31:0] exp_words[$];
      int n, exp_ovr, exp_und, frames;
      bit m;
      do_reset();
      m = 1'($urandom_range(0, 1));
      mute = m;
      n = $urandom_range(0, 6);
      exp_ovr = 0;
      for (int k = 0; k < n; k++) begin
        logic [31:0] w;
        w = $urandom;
        if (model.size() < FIFO_DEPTH) model.push_back(w);
        else exp_ovr++;
        push_pair(w[31:16], w[15:0]);
      end
      frames = model.size() + 1;
      exp_und = 0;
      for (int f = 0; f < frames; f++) begin
        if (model.size() == 0) begin
          exp_words.push_back(32'h0);
          exp_und++;
        end else begin
          logic [31:0] h;
          h = model.pop_front();
          exp_words.push_back(m ? 32'h0 : h);
        end
      end
      enable = 1;
      wait_bits(32 * frames);
      stop_at_frame_end();
      for (int f = 0; f < frames; f++) begin
        n_checks++;
        if (rx_data.size() < 32 * (f + 1) || frame_word(f) !== exp_words[f])
          $display("FAIL rand%0d_frame%0d: got %h want %h", it, f,
                   (rx_data.size() >= 32 * (f + 1)) ? frame_word(f) : 32'hx, exp_words[f]);
        else n_pass++;
      end
      n_checks++;
      if (und_cnt != exp_und || ovr_cnt != exp_ovr)
        $display("FAIL rand%0d_pulses: und=%0d ovr=%0d want %0d/%0d", it, und_cnt, ovr_cnt, exp_und, exp_ovr);
      else n_pass++;
      n_checks++;
      if (period_bad != 0 || edge_bad != 0 || fifo_level !== '0)
        $display("FAIL rand%0d_timing: period_bad=%0d edge_bad=%0d level=%0d want 0/0/0", it, period_bad, edge_bad, fifo_level);
      else n_pass++;
    end
    mute = 0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_overrun();
    test_mute();
    test_full_push_pop();
    test_enable_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
